// File: rtl/weight_update_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// weight_update_ctrl_pkg
// Shared definitions for the single-layer weight-update sequencer:
//   - default widths for sample address, epoch counter and data path
//   - state encoding of the sequencer FSM
// Imported by weight_update_ctrl and sample_epoch_counter.
// ---------------------------------------------------------------------------
package weight_update_ctrl_pkg;

  // Default widths
  localparam int SAMPLE_AW_DEF = 8;   // sample address width
  localparam int EPOCH_W_DEF   = 16;  // epoch counter width
  localparam int DW_DEF        = 32;  // prediction / target / error width

  // Sequencer state encoding
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_LAUNCH   = 3'd1;
  localparam state_t ST_FWD_WAIT = 3'd2;
  localparam state_t ST_ERR      = 3'd3;
  localparam state_t ST_GEN      = 3'd4;
  localparam state_t ST_APPLY    = 3'd5;
  localparam state_t ST_NEXT     = 3'd6;
  localparam state_t ST_FINISH   = 3'd7;

endpackage

// File: rtl/weight_update_ctrl_sample_epoch_counter.sv
// ---------------------------------------------------------------------------
// sample_epoch_counter
// Sample index and completed-epoch counters for the weight-update sequencer.
// On ld the per-run limits are latched (num_samples of 0 is treated as 1) and
// both counters are cleared. On adv the sample index steps; after the last
// sample it wraps to 0 and the epoch counter increments.
//
// Ports:
//   CLK          in   clock, rising edge
//   RST_N        in   synchronous active-low reset
//   ld           in   latch limits and clear counters (start of a run)
//   adv          in   advance to the next sample
//   num_samples  in   samples per epoch (0 treated as 1)
//   num_epochs   in   epochs to run
//   sample_addr  out  current sample index
//   epoch        out  completed-epoch count
//   last_sample  out  current sample is the last one of the epoch
//   last_epoch   out  completing this epoch reaches the latched epoch count
// ---------------------------------------------------------------------------
module sample_epoch_counter
  import weight_update_ctrl_pkg::*;
#(
  parameter int SAMPLE_AW = SAMPLE_AW_DEF,
  parameter int EPOCH_W   = EPOCH_W_DEF
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 ld,
  input  logic                 adv,
  input  logic [SAMPLE_AW-1:0] num_samples,
  input  logic [EPOCH_W-1:0]   num_epochs,
  output logic [SAMPLE_AW-1:0] sample_addr,
  output logic [EPOCH_W-1:0]   epoch,
  output logic                 last_sample,
  output logic                 last_epoch
);

  localparam logic [SAMPLE_AW-1:0] SAMPLE_ZERO = {SAMPLE_AW{1'b0}};
  localparam logic [SAMPLE_AW-1:0] SAMPLE_ONE  = {{(SAMPLE_AW-1){1'b0}}, 1'b1};
  localparam logic [EPOCH_W-1:0]   EPOCH_ZERO  = {EPOCH_W{1'b0}};
  localparam logic [EPOCH_W-1:0]   EPOCH_ONE   = {{(EPOCH_W-1){1'b0}}, 1'b1};

  // Latched index of the last sample; storing N-1 folds the "0 means 1" rule in.
  logic [SAMPLE_AW-1:0] last_idx_r;
  logic [EPOCH_W-1:0]   num_epochs_r;
  logic [SAMPLE_AW-1:0] sample_r;
  logic [EPOCH_W-1:0]   epoch_r;

  // Latched run limits and sample/epoch counters
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      last_idx_r   <= SAMPLE_ZERO;
      num_epochs_r <= EPOCH_ZERO;
      sample_r     <= SAMPLE_ZERO;
      epoch_r      <= EPOCH_ZERO;
    end else if (ld) begin
      last_idx_r   <= (num_samples == SAMPLE_ZERO) ? SAMPLE_ZERO : (num_samples - SAMPLE_ONE);
      num_epochs_r <= num_epochs;
      sample_r     <= SAMPLE_ZERO;
      epoch_r      <= EPOCH_ZERO;
    end else if (adv) begin
      if (sample_r == last_idx_r) begin
        sample_r <= SAMPLE_ZERO;
        epoch_r  <= epoch_r + EPOCH_ONE;
      end else begin
        sample_r <= sample_r + SAMPLE_ONE;
      end
    end else begin
      sample_r <= sample_r;
      epoch_r  <= epoch_r;
    end
  end

  // Boundary flags decoded from the registered counters
  always_comb begin
    last_sample = (sample_r == last_idx_r);
    last_epoch  = ((epoch_r + EPOCH_ONE) == num_epochs_r);
  end

  assign sample_addr = sample_r;
  assign epoch       = epoch_r;

endmodule

// File: rtl/weight_update_ctrl.sv
// ---------------------------------------------------------------------------
// weight_update_ctrl
// Training sequencer for the single-layer update path. For every sample it
// launches the forward pass, registers the error d = target - prediction,
// and, when d is non-zero, strobes the delta-weight generator (gen) and then
// the weight write (w_we). Runs num_epochs passes over num_samples samples.
//
// Optional feature (macro WEIGHT_UPDATE_EARLY_STOP_EN): when defined, an
// epoch that finishes with err_count == 0 ends training immediately; the
// converged epoch is included in the epoch count.
//
// Ports:
//   CLK          in   clock, rising edge
//   RST_N        in   synchronous active-low reset
//   start        in   one-cycle pulse, starts training when idle
//   num_samples  in   samples per epoch (0 treated as 1), latched on start
//   num_epochs   in   epochs to run (0 finishes immediately), latched on start
//   sample_addr  out  current sample index for input/target memories
//   fwd_start    out  one-cycle forward-pass launch
//   fwd_done     in   forward result valid (only looked at while waiting)
//   prediction   in   signed forward output
//   target       in   signed desired output for sample_addr
//   d            out  registered error target - prediction (wraps)
//   gen          out  one-cycle delta-weight generator strobe
//   w_we         out  one-cycle weight write enable
//   busy         out  high whenever not idle
//   done         out  one-cycle pulse at end of training
//   epoch        out  completed-epoch count
//   err_count    out  samples with d != 0 in the current epoch
// ---------------------------------------------------------------------------
module weight_update_ctrl
  import weight_update_ctrl_pkg::*;
#(
  parameter int SAMPLE_AW = SAMPLE_AW_DEF,
  parameter int EPOCH_W   = EPOCH_W_DEF,
  parameter int DW        = DW_DEF
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 start,
  input  logic [SAMPLE_AW-1:0] num_samples,
  input  logic [EPOCH_W-1:0]   num_epochs,
  output logic [SAMPLE_AW-1:0] sample_addr,
  output logic                 fwd_start,
  input  logic                 fwd_done,
  input  logic [DW-1:0]        prediction,
  input  logic [DW-1:0]        target,
  output logic [DW-1:0]        d,
  output logic                 gen,
  output logic                 w_we,
  output logic                 busy,
  output logic                 done,
  output logic [EPOCH_W-1:0]   epoch,
  output logic [SAMPLE_AW:0]   err_count
);

  localparam logic [DW-1:0]      D_ZERO   = {DW{1'b0}};
  localparam logic [EPOCH_W-1:0] EPOCH_Z  = {EPOCH_W{1'b0}};
  localparam logic [SAMPLE_AW:0] ERR_ZERO = {(SAMPLE_AW+1){1'b0}};
  localparam logic [SAMPLE_AW:0] ERR_ONE  = {{SAMPLE_AW{1'b0}}, 1'b1};

  state_t               state_r;
  state_t               next_state_s;

  logic [DW-1:0]        d_r;
  logic [SAMPLE_AW:0]   err_cnt_r;
  logic                 fwd_start_r;
  logic                 gen_r;
  logic                 w_we_r;
  logic                 busy_r;
  logic                 done_r;

  logic                 fwd_start_nx_s;
  logic                 gen_nx_s;
  logic                 w_we_nx_s;
  logic                 busy_nx_s;
  logic                 done_nx_s;
  logic                 cnt_ld_s;
  logic                 cnt_adv_s;
  logic                 d_ld_s;
  logic                 err_inc_s;
  logic                 err_clr_s;
  logic                 last_sample_s;
  logic                 last_epoch_s;

  sample_epoch_counter #(
    .SAMPLE_AW (SAMPLE_AW),
    .EPOCH_W   (EPOCH_W)
  ) u_cnt (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .ld          (cnt_ld_s),
    .adv         (cnt_adv_s),
    .num_samples (num_samples),
    .num_epochs  (num_epochs),
    .sample_addr (sample_addr),
    .epoch       (epoch),
    .last_sample (last_sample_s),
    .last_epoch  (last_epoch_s)
  );

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (num_epochs == EPOCH_Z) begin
            next_state_s = ST_FINISH;
          end else begin
            next_state_s = ST_LAUNCH;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LAUNCH:   next_state_s = ST_FWD_WAIT;
      ST_FWD_WAIT: begin
        if (fwd_done) begin
          next_state_s = ST_ERR;
        end else begin
          next_state_s = ST_FWD_WAIT;
        end
      end
      ST_ERR: begin
        if (d_r == D_ZERO) begin
          next_state_s = ST_NEXT;
        end else begin
          next_state_s = ST_GEN;
        end
      end
      ST_GEN:      next_state_s = ST_APPLY;
      ST_APPLY:    next_state_s = ST_NEXT;
      ST_NEXT: begin
        if (last_sample_s) begin
          if (last_epoch_s) begin
            next_state_s = ST_FINISH;
`ifdef WEIGHT_UPDATE_EARLY_STOP_EN
          end else if (err_cnt_r == ERR_ZERO) begin
            // Converged: a whole epoch produced no error.
            next_state_s = ST_FINISH;
`endif
          end else begin
            next_state_s = ST_LAUNCH;
          end
        end else begin
          next_state_s = ST_LAUNCH;
        end
      end
      ST_FINISH:   next_state_s = ST_IDLE;
      default:     next_state_s = ST_IDLE;
    endcase
  end

  // FSM output decode; strobes are decoded from the next state so their
  // registered copies are high exactly while the FSM sits in that state.
  always_comb begin
    fwd_start_nx_s = (next_state_s == ST_LAUNCH);
    gen_nx_s       = (next_state_s == ST_GEN);
    w_we_nx_s      = (next_state_s == ST_APPLY);
    done_nx_s      = (next_state_s == ST_FINISH);
    busy_nx_s      = (next_state_s != ST_IDLE);
    cnt_ld_s       = (state_r == ST_IDLE) && start;
    cnt_adv_s      = (state_r == ST_NEXT);
    d_ld_s         = (state_r == ST_FWD_WAIT) && fwd_done;
    err_inc_s      = (state_r == ST_ERR) && (d_r != D_ZERO);
    // Clear at a run start, or at an epoch boundary when another epoch follows;
    // on the final epoch the count is left visible until the next start.
    err_clr_s      = cnt_ld_s ||
                     (cnt_adv_s && last_sample_s && (next_state_s == ST_LAUNCH));
  end

  // Registered strobes and status
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      fwd_start_r <= 1'b0;
      gen_r       <= 1'b0;
      w_we_r      <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      fwd_start_r <= fwd_start_nx_s;
      gen_r       <= gen_nx_s;
      w_we_r      <= w_we_nx_s;
      done_r      <= done_nx_s;
      busy_r      <= busy_nx_s;
    end
  end

  // Error register: two's-complement difference wrapped to DW bits
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      d_r <= D_ZERO;
    end else if (d_ld_s) begin
      d_r <= target - prediction;
    end else begin
      d_r <= d_r;
    end
  end

  // Per-epoch count of samples that required a weight update
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      err_cnt_r <= ERR_ZERO;
    end else if (err_clr_s) begin
      err_cnt_r <= ERR_ZERO;
    end else if (err_inc_s) begin
      err_cnt_r <= err_cnt_r + ERR_ONE;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign fwd_start = fwd_start_r;
  assign gen       = gen_r;
  assign w_we      = w_we_r;
  assign done      = done_r;
  assign busy      = busy_r;
  assign d         = d_r;
  assign err_count = err_cnt_r;

endmodule

// File: tb/tb_weight_update_ctrl.sv
// ---------------------------------------------------------------------------
// tb_weight_update_ctrl
// Self-checking bench for weight_update_ctrl. Each run first computes, from
// the training rules alone, the list of forward results it will feed, the
// expected error per sample, the expected number of updates, the final epoch
// and err_count; it then plays a forward-pass responder and compares the
// DUT's strobes, latencies and status against that list.
// ---------------------------------------------------------------------------
module tb_weight_update_ctrl;

  localparam int JOB_LIMIT = 4000;
`ifdef WEIGHT_UPDATE_EARLY_STOP_EN
  localparam bit EARLY_STOP = 1'b1;
`else
  localparam bit EARLY_STOP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  num_samples = 8'd0;
  logic [15:0] num_epochs = 16'd0;
  logic [7:0]  sample_addr;
  logic        fwd_start;
  logic        fwd_done = 1'b0;
  logic [31:0] prediction = 32'd0;
  logic [31:0] target = 32'd0;
  logic [31:0] d;
  logic        gen;
  logic        w_we;
  logic        busy;
  logic        done;
  logic [15:0] epoch;
  logic [8:0]  err_count;

  int errors = 0;
  int checks = 0;

  weight_update_ctrl dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .start       (start),
    .num_samples (num_samples),
    .num_epochs  (num_epochs),
    .sample_addr (sample_addr),
    .fwd_start   (fwd_start),
    .fwd_done    (fwd_done),
    .prediction  (prediction),
    .target      (target),
    .d           (d),
    .gen         (gen),
    .w_we        (w_we),
    .busy        (busy),
    .done        (done),
    .epoch       (epoch),
    .err_count   (err_count)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_idle_after_reset();
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_fwd_start", 64'(fwd_start), 64'd0);
    check_eq("rst_gen", 64'(gen), 64'd0);
    check_eq("rst_w_we", 64'(w_we), 64'd0);
    check_eq("rst_sample_addr", 64'(sample_addr), 64'd0);
    check_eq("rst_epoch", 64'(epoch), 64'd0);
    check_eq("rst_err_count", 64'(err_count), 64'd0);
    check_eq("rst_d", 64'(d), 64'd0);
  endtask

  // mode: 0 all d==0, 1 target=1/pred=-1, 2 wrap case, 3 random mix
  // fixed_dly: forward latency in FWD_WAIT cycles beyond the first (-1 random)
  // abort_sample: assert reset during gen of this sample index (-1 never)
  task automatic run_job(input int ns, input int ne, input int mode,
                         input int fixed_dly, input int abort_sample);
    logic [31:0] tq[$];
    logic [31:0] pq[$];
    logic [31:0] dq[$];
    int          aq[$];
    int          ns_eff, exp_epoch, exp_err, exp_gens;
    int          cyc, call, wait_cnt, since_fd, fwds, gens, wes;
    bit          fin, done_seen, prev_gen, exp_upd;
    logic [31:0] t, p;

    // ---- reference model: what the run should produce ----
    ns_eff = (ns == 0) ? 1 : ns;
    exp_epoch = 0; exp_err = 0; exp_gens = 0;
    fin = (ne == 0);
    while (!fin) begin
      for (int s = 0; s < ns_eff; s++) begin
        case (mode)
          0: begin p = $urandom; t = p; end
          1: begin t = 32'd1; p = 32'hFFFF_FFFF; end
          2: begin t = 32'h7FFF_FFFF; p = 32'hFFFF_FFFF; end
          default: begin
            p = $urandom;
            t = ($urandom_range(0, 2) == 0) ? p : 32'($urandom);
          end
        endcase
        tq.push_back(t); pq.push_back(p); dq.push_back(t - p); aq.push_back(s);
        if (t != p) begin exp_err++; exp_gens++; end
      end
      exp_epoch++;
      if (exp_epoch == ne) fin = 1'b1;
      else if (EARLY_STOP && exp_err == 0) fin = 1'b1;
      else exp_err = 0;
    end

    // ---- drive the run ----
    @(negedge CLK);
    start = 1'b1; num_samples = 8'(ns); num_epochs = 16'(ne); fwd_done = 1'b0;
    cyc = 0; call = 0; wait_cnt = 0; since_fd = -1; fwds = 0; gens = 0; wes = 0;
    done_seen = 1'b0; prev_gen = 1'b0; exp_upd = 1'b0;

    while (!done_seen && cyc < JOB_LIMIT) begin
      @(negedge CLK);
      cyc++;
      start = 1'b0;
      fwd_done = 1'b0;
      if (since_fd >= 0) since_fd++;

      check_eq("strobe_excl", 64'(int'(fwd_start) + int'(gen) + int'(w_we) <= 1), 64'd1);
      check_eq("busy_run", 64'(busy), 64'd1);

      if (gen) begin
        gens++;
        if (call == 0) check_eq("gen_before_fwd", 64'(call), 64'd1);
        else begin
          check_eq("gen_latency", 64'(since_fd), 64'd2);
          check_eq("gen_d", 64'(d), 64'(dq[call-1]));
          if (mode == 2) check_eq("wrap_d", 64'(d), 64'h8000_0000);
        end
        if (abort_sample >= 0 && int'(sample_addr) == abort_sample) begin
          RST_N = 1'b0;
          @(negedge CLK);
          check_idle_after_reset();
          RST_N = 1'b1;
          return;
        end
      end

      if (w_we) begin
        wes++;
        check_eq("w_we_after_gen", 64'(prev_gen), 64'd1);
      end

      if (fwd_start) begin
        if (call > 0) check_eq("sample_latency", 64'(since_fd), exp_upd ? 64'd5 : 64'd3);
        if (call >= tq.size()) check_eq("extra_fwd_start", 64'(call), 64'(tq.size() - 1));
        else begin
          check_eq("sample_addr", 64'(sample_addr), 64'(aq[call]));
          exp_upd = (dq[call] != 32'd0);
        end
        fwds++; call++; since_fd = -1;
        wait_cnt = ((fixed_dly >= 0) ? fixed_dly : $urandom_range(0, 3)) + 1;
      end else if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0 && call <= tq.size()) begin
          fwd_done = 1'b1;
          prediction = pq[call-1];
          target = tq[call-1];
          since_fd = 0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        // Stray fwd_done outside FWD_WAIT must be ignored.
        fwd_done = 1'b1;
        prediction = $urandom;
        target = $urandom;
      end

      if (done) begin
        done_seen = 1'b1;
        start = 1'b0;
        check_eq("done_epoch", 64'(epoch), 64'(exp_epoch));
        check_eq("done_err_count", 64'(err_count), 64'(exp_err));
        check_eq("fwd_count", 64'(fwds), 64'(tq.size()));
        check_eq("gen_count", 64'(gens), 64'(exp_gens));
        check_eq("w_we_count", 64'(wes), 64'(exp_gens));
        if (call > 0) begin
          check_eq("done_latency", 64'(since_fd), exp_upd ? 64'd5 : 64'd3);
          check_eq("d_hold", 64'(d), 64'(dq[call-1]));
        end else begin
          check_eq("done_latency_zero", 64'(cyc >= 1 && cyc <= 2), 64'd1);
        end
      end else begin
        // Inputs may wander while busy; start must be ignored.
        num_samples = 8'($urandom);
        num_epochs = 16'($urandom);
        start = ($urandom_range(0, 7) == 0);
      end
      prev_gen = gen;
    end

    check_eq("done_within_budget", 64'(done_seen), 64'd1);
    @(negedge CLK);
    start = 1'b0;
    fwd_done = 1'b0;
    check_eq("idle_busy", 64'(busy), 64'd0);
    check_eq("idle_done", 64'(done), 64'd0);
    check_eq("idle_epoch_hold", 64'(epoch), 64'(exp_epoch));
  endtask

  initial begin
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    check_idle_after_reset();
    RST_N = 1'b1;

    run_job(3, 2, 0, 1, -1);    // no updates: 6 launches, fwd_done 2 cycles after fwd_start
    run_job(1, 1, 1, 0, -1);    // d = 2, single update
    run_job(4, 0, 3, -1, -1);   // zero epochs: immediate done
    run_job(3, 1, 1, 0, 1);     // reset during gen of the second sample
    run_job(2, 1, 1, 0, -1);    // restart after reset begins at sample 0
    run_job(1, 1, 2, -1, -1);   // wrapped difference still updates
    run_job(4, 10, 0, -1, -1);  // converging first epoch
    run_job(0, 2, 3, -1, -1);   // num_samples 0 behaves as 1
    for (int j = 0; j < 8; j++) begin
      run_job($urandom_range(0, 5), $urandom_range(0, 3), 3, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
